// File: rtl/fifo_rd_arb.sv
// Round-robin read-port arbiter and burst sequencer for the async FIFO read domain.
// Optional stall watchdog is enabled by defining FIFO_RD_ARB_WDOG_EN.
module fifo_rd_arb #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int BL_WIDTH    = 5,
    parameter int BURST_MAX   = 16,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                         r_clk,
    input  logic                         r_rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BL_WIDTH-1:0]  req_len,
    output logic [NUM_REQ-1:0]           gnt,
    input  logic                         r_empty,
    output logic                         r_pop,
    input  logic [DATA_WIDTH-1:0]        r_data,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [NUM_REQ-1:0]           rd_valid,
    output logic                         rd_last,
    output logic                         busy,
    output logic                         wdog_abort
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int REM_W = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [IDX_W-1:0]   g_idx, g_idx_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDX_W-1:0]   g_next;
    logic [REM_W-1:0]   remaining, remaining_nxt;
    logic [IDX_W-1:0]   pick_idx, cand;
    logic               pick_found;
    logic               pop_acc;
    logic               last_pop;
    logic               wdog_trip;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    function automatic logic [REM_W-1:0] clamp_len(input logic [BL_WIDTH-1:0] len);
        if (len == '0)
            return REM_W'(1);
        else if (int'(len) > BURST_MAX)
            return REM_W'(BURST_MAX);
        else
            return REM_W'(len);
    endfunction

    // Pop is a pure function of registered state and req, so an abort drops it in the same cycle.
    assign r_pop    = (state == BURST) && req[g_idx] && (remaining != '0);
    assign pop_acc  = r_pop && !r_empty;
    assign last_pop = pop_acc && (remaining == REM_W'(1));
    assign busy     = (state != IDLE);
    assign g_next   = wrap_add(g_idx, 1);

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_add(rr_ptr, i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        g_idx_nxt     = g_idx;
        rr_ptr_nxt    = rr_ptr;
        remaining_nxt = remaining;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (pick_found) begin
                    state_nxt          = BURST;
                    gnt_nxt[pick_idx]  = 1'b1;
                    g_idx_nxt          = pick_idx;
                    remaining_nxt      = clamp_len(req_len[int'(pick_idx)*BL_WIDTH +: BL_WIDTH]);
                end
            end
            BURST: begin
                if (!req[g_idx]) begin
                    // With req low no pop can be accepted, so an abort never needs DRAIN.
                    state_nxt  = IDLE;
                    gnt_nxt    = '0;
                    rr_ptr_nxt = g_next;
                end else if (pop_acc) begin
                    remaining_nxt = remaining - 1'b1;
                    if (last_pop) state_nxt = DRAIN;
                end else if (wdog_trip) begin
                    state_nxt  = IDLE;
                    gnt_nxt    = '0;
                    rr_ptr_nxt = g_next;
                end
            end
            DRAIN: begin
                state_nxt  = IDLE;
                gnt_nxt    = '0;
                rr_ptr_nxt = g_next;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            g_idx     <= '0;
            rr_ptr    <= '0;
            remaining <= '0;
            rd_valid  <= '0;
            rd_last   <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            g_idx     <= g_idx_nxt;
            rr_ptr    <= rr_ptr_nxt;
            remaining <= remaining_nxt;
            rd_valid  <= pop_acc ? gnt : '0;
            rd_last   <= last_pop;
        end
    end

    // The RAM already registers r_data one cycle after the pop, aligned with rd_valid.
    assign rd_data = (|rd_valid) ? r_data : '0;

`ifdef FIFO_RD_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);

    logic [WD_W-1:0] stall_cnt;

    assign wdog_trip = r_pop && r_empty && (stall_cnt == WD_W'(WDOG_CYCLES - 1));

    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            stall_cnt  <= '0;
            wdog_abort <= 1'b0;
        end else begin
            wdog_abort <= wdog_trip;
            if (pop_acc || state_nxt != BURST)
                stall_cnt <= '0;
            else if (r_pop && r_empty)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign wdog_trip  = 1'b0;
    assign wdog_abort = 1'b0;
`endif

endmodule
